// File: rtl/tea_pkg.sv
// Shared constants and FSM state encoding for the dual-engine TEA block.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA  = 32'h9e3779b9;
    localparam int          TEA_ROUNDS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tea_engine.sv
// Iterative TEA engine: one full round per clock, a write-back cycle, then DONE.
// DECIPHER selects the inverse round and the starting value of sum.
module tea_engine
    import tea_pkg::*;
#(
    parameter int          WORD_SIZE    = 128,
    parameter logic [31:0] DELTA        = TEA_DELTA,
    parameter int          ROUND_NUMBER = TEA_ROUNDS,
    parameter bit          DECIPHER     = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] v0_in,
    input  logic [WORD_SIZE-1:0] v1_in,
    input  logic [WORD_SIZE-1:0] k0_in,
    input  logic [WORD_SIZE-1:0] k1_in,
    input  logic [WORD_SIZE-1:0] k2_in,
    input  logic [WORD_SIZE-1:0] k3_in,
    output logic [WORD_SIZE-1:0] out0,
    output logic [WORD_SIZE-1:0] out1,
    output logic                 done
);

    localparam int                   CNT_W     = $clog2(ROUND_NUMBER + 1);
    localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(ROUND_NUMBER);
    localparam logic [WORD_SIZE-1:0] DELTA_W   = WORD_SIZE'(DELTA);
    localparam logic [WORD_SIZE-1:0] SUM_START =
        DECIPHER ? WORD_SIZE'(DELTA_W * WORD_SIZE'(ROUND_NUMBER)) : '0;

    state_t state_reg, state_next;

    logic [WORD_SIZE-1:0] v0_reg, v1_reg, sum_reg;
    logic [WORD_SIZE-1:0] k0_reg, k1_reg, k2_reg, k3_reg;
    logic [WORD_SIZE-1:0] out0_reg, out1_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [WORD_SIZE-1:0] v0_next, v1_next, sum_next;
    logic                 last_round;

    function automatic logic [WORD_SIZE-1:0] tea_f(
        input logic [WORD_SIZE-1:0] v,
        input logic [WORD_SIZE-1:0] ka,
        input logic [WORD_SIZE-1:0] kb,
        input logic [WORD_SIZE-1:0] s
    );
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    // Each half of the round uses the other half's freshly updated value.
    generate
        if (DECIPHER) begin : g_decipher
            assign v1_next  = v1_reg - tea_f(v0_reg, k2_reg, k3_reg, sum_reg);
            assign v0_next  = v0_reg - tea_f(v1_next, k0_reg, k1_reg, sum_reg);
            assign sum_next = sum_reg - DELTA_W;
        end else begin : g_cipher
            assign sum_next = sum_reg + DELTA_W;
            assign v0_next  = v0_reg + tea_f(v1_reg, k0_reg, k1_reg, sum_next);
            assign v1_next  = v1_reg + tea_f(v0_next, k2_reg, k3_reg, sum_next);
        end
    endgenerate

    assign last_round = (cnt_reg == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_round) state_next = DONE;
            DONE:    if (!start)     state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // RUN spends ROUND_NUMBER clocks on rounds and one more publishing the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_reg   <= '0;
            v1_reg   <= '0;
            sum_reg  <= '0;
            k0_reg   <= '0;
            k1_reg   <= '0;
            k2_reg   <= '0;
            k3_reg   <= '0;
            out0_reg <= '0;
            out1_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        v0_reg  <= v0_in;
                        v1_reg  <= v1_in;
                        k0_reg  <= k0_in;
                        k1_reg  <= k1_in;
                        k2_reg  <= k2_in;
                        k3_reg  <= k3_in;
                        sum_reg <= SUM_START;
                        cnt_reg <= '0;
                    end
                end
                RUN: begin
                    if (last_round) begin
                        out0_reg <= v0_reg;
                        out1_reg <= v1_reg;
                    end else begin
                        v0_reg  <= v0_next;
                        v1_reg  <= v1_next;
                        sum_reg <= sum_next;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out0 = out0_reg;
    assign out1 = out1_reg;
    assign done = (state_reg == DONE);

endmodule

// File: rtl/dut.sv
// Dual TEA block: independent cipher and decipher engines sharing block and key inputs.
module dut
    import tea_pkg::*;
#(
    parameter int          WORD_SIZE    = 128,
    parameter logic [31:0] DELTA        = TEA_DELTA,
    parameter int          ROUND_NUMBER = TEA_ROUNDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iStartCipher,
    input  logic                 iStartDecipher,
    input  logic [WORD_SIZE-1:0] iV0,
    input  logic [WORD_SIZE-1:0] iV1,
    input  logic [WORD_SIZE-1:0] iK0,
    input  logic [WORD_SIZE-1:0] iK1,
    input  logic [WORD_SIZE-1:0] iK2,
    input  logic [WORD_SIZE-1:0] iK3,
    output logic [WORD_SIZE-1:0] oC0,
    output logic [WORD_SIZE-1:0] oC1,
    output logic [WORD_SIZE-1:0] oV0,
    output logic [WORD_SIZE-1:0] oV1,
    output logic                 oDoneCipher,
    output logic                 oDoneDecipher
);

    tea_engine #(
        .WORD_SIZE(WORD_SIZE), .DELTA(DELTA), .ROUND_NUMBER(ROUND_NUMBER), .DECIPHER(1'b0)
    ) cifrar (
        .clk(clk), .rst(rst), .start(iStartCipher),
        .v0_in(iV0), .v1_in(iV1),
        .k0_in(iK0), .k1_in(iK1), .k2_in(iK2), .k3_in(iK3),
        .out0(oC0), .out1(oC1), .done(oDoneCipher)
    );

    tea_engine #(
        .WORD_SIZE(WORD_SIZE), .DELTA(DELTA), .ROUND_NUMBER(ROUND_NUMBER), .DECIPHER(1'b1)
    ) descifrar (
        .clk(clk), .rst(rst), .start(iStartDecipher),
        .v0_in(iV0), .v1_in(iV1),
        .k0_in(iK0), .k1_in(iK1), .k2_in(iK2), .k3_in(iK3),
        .out0(oV0), .out1(oV1), .done(oDoneDecipher)
    );

endmodule

// File: tb/tb_dut.sv
// Directed checks of the dual TEA block at 32-bit and 128-bit word sizes.
module tb_dut;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        a_sc, a_sd, a_dc, a_dd;
    logic [31:0] a_v0, a_v1, a_k0, a_k1, a_k2, a_k3, a_c0, a_c1, a_p0, a_p1;
    // 128-bit instance
    logic         b_sc, b_sd, b_dc, b_dd;
    logic [127:0] b_v0, b_v1, b_k0, b_k1, b_k2, b_k3, b_c0, b_c1, b_p0, b_p1;

    int checks = 0;
    int passed = 0;

    dut #(.WORD_SIZE(32)) u32 (
        .clk(clk), .rst(rst), .iStartCipher(a_sc), .iStartDecipher(a_sd),
        .iV0(a_v0), .iV1(a_v1), .iK0(a_k0), .iK1(a_k1), .iK2(a_k2), .iK3(a_k3),
        .oC0(a_c0), .oC1(a_c1), .oV0(a_p0), .oV1(a_p1),
        .oDoneCipher(a_dc), .oDoneDecipher(a_dd)
    );

    dut #(.WORD_SIZE(128)) u128 (
        .clk(clk), .rst(rst), .iStartCipher(b_sc), .iStartDecipher(b_sd),
        .iV0(b_v0), .iV1(b_v1), .iK0(b_k0), .iK1(b_k1), .iK2(b_k2), .iK3(b_k3),
        .oC0(b_c0), .oC1(b_c1), .oV0(b_p0), .oV1(b_p1),
        .oDoneCipher(b_dc), .oDoneDecipher(b_dd)
    );

    // Reference TEA on 128-bit variables, masked to w bits
    task automatic model_enc(input int w, input logic [127:0] x0, y0, k0, k1, k2, k3,
                             output logic [127:0] r0, r1);
        logic [127:0] m, s, d, x, y;
        m = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
        d = 128'h9e3779b9 & m;
        s = '0;
        x = x0 & m;
        y = y0 & m;
        for (int i = 0; i < 32; i++) begin
            s = (s + d) & m;
            x = (x + ((((y << 4) + k0) & m) ^ ((y + s) & m) ^ (((y >> 5) + k1) & m))) & m;
            y = (y + ((((x << 4) + k2) & m) ^ ((x + s) & m) ^ (((x >> 5) + k3) & m))) & m;
        end
        r0 = x;
        r1 = y;
    endtask

    task automatic model_dec(input int w, input logic [127:0] x0, y0, k0, k1, k2, k3,
                             output logic [127:0] r0, r1);
        logic [127:0] m, s, d, x, y;
        m = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
        d = 128'h9e3779b9 & m;
        s = (d * 128'd32) & m;
        x = x0 & m;
        y = y0 & m;
        for (int i = 0; i < 32; i++) begin
            y = (y - ((((x << 4) + k2) & m) ^ ((x + s) & m) ^ (((x >> 5) + k3) & m))) & m;
            x = (x - ((((y << 4) + k0) & m) ^ ((y + s) & m) ^ (((y >> 5) + k1) & m))) & m;
            s = (s - d) & m;
        end
        r0 = x;
        r1 = y;
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return a_dc;
            1:       return a_dd;
            2:       return b_dc;
            default: return b_dd;
        endcase
    endfunction

    // Caller raises start just before; returns clocks from the start sample to done (100 = timeout)
    task automatic wait_done(input int sel, output int cyc);
        cyc = 0;
        @(posedge clk);
        #1;
        while (!done_of(sel) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        {a_sc, a_sd, b_sc, b_sd} = '0;
        {a_v0, a_v1, a_k0, a_k1, a_k2, a_k3} = '0;
        {b_v0, b_v1, b_k0, b_k1, b_k2, b_k3} = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_c0, a_c1, a_p0, a_p1} !== '0) $display("FAIL reset_a_out: got %h want 0", {a_c0, a_c1, a_p0, a_p1});
        else passed++;
        checks++;
        if ({b_c0, b_c1, b_p0, b_p1} !== '0) $display("FAIL reset_b_out: got %h want 0", {b_c0, b_c1, b_p0, b_p1});
        else passed++;
        checks++;
        if ({a_dc, a_dd, b_dc, b_dd} !== 4'b0) $display("FAIL reset_done: got %b want 0000", {a_dc, a_dd, b_dc, b_dd});
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        $display("reset: outputs=%h done=%b", {a_c0, a_c1}, {a_dc, a_dd, b_dc, b_dd});
    endtask

    task automatic test_cipher_zero;
        int cyc;
        @(negedge clk);
        a_sc = 1'b1;
        wait_done(0, cyc);
        $display("cipher32 zero: cyc=%0d c0=%h c1=%h", cyc, a_c0, a_c1);
        checks++;
        if (cyc !== 33) $display("FAIL c32_latency: got %0d want 33", cyc); else passed++;
        checks++;
        if (a_c0 !== 32'h41ea3a0a) $display("FAIL c32_c0: got %h want 41ea3a0a", a_c0); else passed++;
        checks++;
        if (a_c1 !== 32'h94baa940) $display("FAIL c32_c1: got %h want 94baa940", a_c1); else passed++;
        @(negedge clk);
        a_sc = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (a_dc !== 1'b0) $display("FAIL c32_done_drop: got %b want 0", a_dc); else passed++;
        checks++;
        if ({a_c0, a_c1} !== 64'h41ea3a0a_94baa940) $display("FAIL c32_hold: got %h want 41ea3a0a94baa940", {a_c0, a_c1});
        else passed++;
    endtask

    task automatic test_decipher_zero;
        int cyc;
        @(negedge clk);
        a_v0 = 32'h41ea3a0a;
        a_v1 = 32'h94baa940;
        a_sd = 1'b1;
        wait_done(1, cyc);
        $display("decipher32: cyc=%0d p0=%h p1=%h", cyc, a_p0, a_p1);
        checks++;
        if (cyc !== 33) $display("FAIL d32_latency: got %0d want 33", cyc); else passed++;
        checks++;
        if ({a_p0, a_p1} !== 64'h0) $display("FAIL d32_plain: got %h want 0", {a_p0, a_p1}); else passed++;
        checks++;
        if ({a_c0, a_c1, a_dc} !== {64'h41ea3a0a_94baa940, 1'b0}) $display("FAIL d32_cipher_idle: got %h want 41ea3a0a94baa940,0", {a_c0, a_c1, a_dc});
        else passed++;
        @(negedge clk);
        a_sd = 1'b0;
    endtask

    task automatic test_roundtrip_128;
        int cyc;
        logic [127:0] e0, e1, p0, p1;
        p0 = 128'h3ca67c8e158908776dcc3a7b41cb88e6;
        p1 = 128'h9a34483d3b1a68a41235130bf207ee95;
        @(negedge clk);
        b_v0 = p0;
        b_v1 = p1;
        b_k0 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        b_k1 = 128'hdeadbeefcafebabe0123456789abcdef;
        b_k2 = 128'h55aa55aa00ff00ff1234432156788765;
        b_k3 = 128'h8000000000000001fedcba9876543210;
        model_enc(128, p0, p1, b_k0, b_k1, b_k2, b_k3, e0, e1);
        b_sc = 1'b1;
        wait_done(2, cyc);
        $display("cipher128: cyc=%0d c0=%h c1=%h", cyc, b_c0, b_c1);
        checks++;
        if (cyc !== 33) $display("FAIL c128_latency: got %0d want 33", cyc); else passed++;
        checks++;
        if ({b_c0, b_c1} !== {e0, e1}) $display("FAIL c128_out: got %h want %h", {b_c0, b_c1}, {e0, e1});
        else passed++;
        @(negedge clk);
        b_sc = 1'b0;
        b_v0 = b_c0;
        b_v1 = b_c1;
        b_sd = 1'b1;
        wait_done(3, cyc);
        $display("decipher128: cyc=%0d p0=%h p1=%h", cyc, b_p0, b_p1);
        checks++;
        if ({b_p0, b_p1} !== {p0, p1}) $display("FAIL d128_roundtrip: got %h want %h", {b_p0, b_p1}, {p0, p1});
        else passed++;
        @(negedge clk);
        b_sd = 1'b0;
    endtask

    task automatic test_hold_start;
        int first_done;
        int drops;
        logic [127:0] e0, e1;
        @(negedge clk);
        a_v0 = 32'h01234567;
        a_v1 = 32'h89abcdef;
        a_k0 = 32'h00112233;
        a_k1 = 32'h44556677;
        a_k2 = 32'h8899aabb;
        a_k3 = 32'hccddeeff;
        model_enc(32, {96'h0, a_v0}, {96'h0, a_v1}, {96'h0, a_k0}, {96'h0, a_k1},
                  {96'h0, a_k2}, {96'h0, a_k3}, e0, e1);
        a_sc = 1'b1;
        first_done = 0;
        drops = 0;
        @(posedge clk);
        for (int c = 1; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (c == 10) begin
                a_v0 = 32'hffff0000;
                a_k0 = 32'h13579bdf;
            end
            if (a_dc && first_done == 0) first_done = c;
            if (!a_dc && first_done != 0) drops++;
        end
        $display("hold32: first_done=%0d drops=%0d c0=%h c1=%h", first_done, drops, a_c0, a_c1);
        checks++;
        if (first_done !== 33) $display("FAIL hold_latency: got %0d want 33", first_done); else passed++;
        checks++;
        if (drops !== 0) $display("FAIL hold_restart: got %0d done drops want 0", drops); else passed++;
        checks++;
        if ({a_c0, a_c1} !== {e0[31:0], e1[31:0]}) $display("FAIL hold_out: got %h want %h", {a_c0, a_c1}, {e0[31:0], e1[31:0]});
        else passed++;
        @(negedge clk);
        a_sc = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (a_dc !== 1'b0) $display("FAIL hold_done_drop: got %b want 0", a_dc); else passed++;
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        logic [127:0] e0, e1;
        @(negedge clk);
        a_v0 = 32'hcafef00d;
        a_v1 = 32'h0badc0de;
        a_k0 = 32'h11111111;
        a_k1 = 32'h22222222;
        a_k2 = 32'h33333333;
        a_k3 = 32'h44444444;
        a_sc = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        $display("reset mid-run: c0=%h c1=%h done=%b", a_c0, a_c1, a_dc);
        checks++;
        if ({a_c0, a_c1} !== 64'h0) $display("FAIL midrst_out: got %h want 0", {a_c0, a_c1}); else passed++;
        checks++;
        if (a_dc !== 1'b0) $display("FAIL midrst_done: got %b want 0", a_dc); else passed++;
        a_sc = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_enc(32, {96'h0, a_v0}, {96'h0, a_v1}, {96'h0, a_k0}, {96'h0, a_k1},
                  {96'h0, a_k2}, {96'h0, a_k3}, e0, e1);
        a_sc = 1'b1;
        wait_done(0, cyc);
        $display("after reset cipher32: cyc=%0d c0=%h c1=%h", cyc, a_c0, a_c1);
        checks++;
        if (cyc !== 33) $display("FAIL midrst_latency: got %0d want 33", cyc); else passed++;
        checks++;
        if ({a_c0, a_c1} !== {e0[31:0], e1[31:0]}) $display("FAIL midrst_rerun: got %h want %h", {a_c0, a_c1}, {e0[31:0], e1[31:0]});
        else passed++;
        @(negedge clk);
        a_sc = 1'b0;
    endtask

    task automatic test_both_engines;
        int cyc;
        logic [127:0] e0, e1, d0, d1;
        @(negedge clk);
        b_v0 = 128'h00000000000000010000000000000002;
        b_v1 = 128'hfedcba9876543210fedcba9876543210;
        b_k0 = 128'h1;
        b_k1 = 128'h2;
        b_k2 = 128'h3;
        b_k3 = 128'h4;
        model_enc(128, b_v0, b_v1, b_k0, b_k1, b_k2, b_k3, e0, e1);
        model_dec(128, b_v0, b_v1, b_k0, b_k1, b_k2, b_k3, d0, d1);
        b_sc = 1'b1;
        b_sd = 1'b1;
        wait_done(2, cyc);
        $display("both128: cyc=%0d dc=%b dd=%b", cyc, b_dc, b_dd);
        checks++;
        if (cyc !== 33) $display("FAIL both_latency: got %0d want 33", cyc); else passed++;
        checks++;
        if (b_dd !== 1'b1) $display("FAIL both_same_clock: got %b want 1", b_dd); else passed++;
        checks++;
        if ({b_c0, b_c1} !== {e0, e1}) $display("FAIL both_cipher: got %h want %h", {b_c0, b_c1}, {e0, e1});
        else passed++;
        checks++;
        if ({b_p0, b_p1} !== {d0, d1}) $display("FAIL both_decipher: got %h want %h", {b_p0, b_p1}, {d0, d1});
        else passed++;
        @(negedge clk);
        b_sc = 1'b0;
        b_sd = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({b_dc, b_dd} !== 2'b00) $display("FAIL both_done_drop: got %b want 00", {b_dc, b_dd}); else passed++;
    endtask

    initial begin
        test_reset;
        test_cipher_zero;
        test_decipher_zero;
        test_roundtrip_128;
        test_hold_start;
        test_reset_mid_run;
        test_both_engines;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
